// File: rtl/hermes_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hermes_pkg
// Brief   : Shared flit type, input-port FSM states and packet field indices.
// Rev     : 1.0  initial release
// ============================================================================
package hermes_pkg;

    localparam int DEFAULT_FLIT_WIDTH = 16;

    typedef logic [DEFAULT_FLIT_WIDTH-1:0] flit_t;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_HEADER  = 3'd2,
        S_SIZE    = 3'd3,
        S_PAYLOAD = 3'd4,
        S_END     = 3'd5
    } in_state_t;

    localparam int HEADER_IDX = 0;
    localparam int SIZE_IDX   = 1;

endpackage
`default_nettype wire

// File: rtl/hermes_flit_fifo.sv
`default_nettype none
// ============================================================================
// Module  : hermes_flit_fifo
// Brief   : Circular flit FIFO with occupancy count and upstream credit.
// Rev     : 1.0  initial release
// ============================================================================
module hermes_flit_fifo
    import hermes_pkg::*;
#(
    parameter int FLIT_WIDTH   = DEFAULT_FLIT_WIDTH,
    parameter int BUFFER_DEPTH = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          push_req,
    input  logic [FLIT_WIDTH-1:0]         wr_data,
    input  logic                          pop_req,
    output logic [FLIT_WIDTH-1:0]         rd_data,
    output logic [$clog2(BUFFER_DEPTH):0] count,
    output logic                          credit
);

    localparam int ADDR_W = $clog2(BUFFER_DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(BUFFER_DEPTH);

    logic [FLIT_WIDTH-1:0] mem [BUFFER_DEPTH];
    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_ptr;
    logic                  push;
    logic                  pop;

    assign credit  = (count != FULL_COUNT);
    assign push    = push_req && credit;
    assign pop     = pop_req && (count != '0);
    assign rd_data = mem[rd_ptr];

    // Storage is not cleared on reset; the pointers alone define what is valid.
    always_ff @(posedge clock) begin
        if (reset && push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/hermes_input_buffer.sv
`default_nettype none
// ============================================================================
// Module  : hermes_input_buffer
// Brief   : Router input port: flit buffering, packet framing, routing request.
// Rev     : 1.0  initial release
// ============================================================================
module hermes_input_buffer
    import hermes_pkg::*;
#(
    parameter int FLIT_WIDTH   = DEFAULT_FLIT_WIDTH,
    parameter int BUFFER_DEPTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rx,
    input  logic [FLIT_WIDTH-1:0] data_in,
    output logic                  credit_o,
    output logic                  h,
    input  logic                  ack_h,
    output logic                  data_av,
    output logic [FLIT_WIDTH-1:0] data_out,
    input  logic                  data_ack,
    output logic                  sender,
    output logic                  eop
);

    localparam int CNT_W = $clog2(BUFFER_DEPTH) + 1;

    in_state_t             state;
    in_state_t             state_next;
    logic [CNT_W-1:0]      count;
    logic [FLIT_WIDTH-1:0] size_cnt;
    logic                  nonempty;
    logic                  nonempty_q;
    logic                  pop;
    logic                  take;

    hermes_flit_fifo #(
        .FLIT_WIDTH   (FLIT_WIDTH),
        .BUFFER_DEPTH (BUFFER_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push_req (rx),
        .wr_data  (data_in),
        .pop_req  (pop),
        .rd_data  (data_out),
        .count    (count),
        .credit   (credit_o)
    );

    assign nonempty = (count != '0);
    assign pop      = data_ack && data_av;
    assign take     = data_ack && nonempty;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // nonempty_q delays a fresh header by one cycle before the request is
    // raised, while a header already queued behind the previous tail is
    // requested straight out of S_IDLE.
    always_ff @(posedge clock) begin
        if (!reset) begin
            size_cnt   <= '0;
            nonempty_q <= 1'b0;
        end else begin
            nonempty_q <= nonempty;
            if (pop && state == S_SIZE) begin
                size_cnt <= data_out;
            end else if (pop && state == S_PAYLOAD) begin
                size_cnt <= size_cnt - FLIT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        h          = 1'b0;
        data_av    = 1'b0;
        sender     = 1'b0;
        eop        = 1'b0;
        case (state)
            S_IDLE: begin
                if (nonempty_q && nonempty) begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                h = 1'b1;
                if (ack_h) begin
                    state_next = S_HEADER;
                end
            end
            S_HEADER: begin
                sender  = 1'b1;
                data_av = nonempty;
                if (take) begin
                    state_next = S_SIZE;
                end
            end
            S_SIZE: begin
                sender  = 1'b1;
                data_av = nonempty;
                if (take) begin
                    state_next = (data_out == '0) ? S_END : S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                sender  = 1'b1;
                data_av = nonempty;
                if (take && size_cnt == FLIT_WIDTH'(1)) begin
                    state_next = S_END;
                end
            end
            S_END: begin
                eop        = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/hermes_input_buffer.md
Name: hermes_input_buffer

Overview:
Router input port stage that directly consumes the flit stream emitted by the DDMA transmit side.
- Buffers incoming flits in a circular FIFO and returns credit upstream.
- Parses packet framing (header, size, payload) and raises a routing request toward the switch-control arbiter.
- Streams the granted packet to the crossbar with a valid/ack handshake.

Parameters:
- FLIT_WIDTH, 16, width of one flit in bits.
- BUFFER_DEPTH, 16, FIFO entries; power of two, minimum 2.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low.
- rx  in  1  upstream flit valid.
- data_in  in  FLIT_WIDTH  upstream flit.
- credit_o  out  1  space available; upstream may assert rx only while high.
- h  out  1  routing request; header flit is at FIFO head.
- ack_h  in  1  routing grant from switch control.
- data_av  out  1  flit valid toward crossbar.
- data_out  out  FLIT_WIDTH  FIFO head flit.
- data_ack  in  1  crossbar consumed data_out this cycle.
- sender  out  1  packet owns an output channel (grant through tail).
- eop  out  1  one-cycle pulse after tail flit is consumed.

Behaviour:
- Reset is synchronous, active-low; clock is clock. While reset=0:
  - wr_ptr, rd_ptr and count are 0; FSM is S_IDLE; the size counter is 0.
  - Outputs: h=0, data_av=0, sender=0, eop=0, credit_o=1.
- Reset mid-packet discards all buffered flits and any partially sent packet. No eop is produced.
- Packet format:
  - flit0 = header (target address).
  - flit1 = size N (unsigned, FLIT_WIDTH bits).
  - then N payload flits. N=0 is legal; the size flit is then the tail.
- FIFO:
  - push = rx && credit_o; pop = data_ack && data_av.
  - credit_o = (count != BUFFER_DEPTH), decoded combinationally from the registered count.
  - rx while credit_o=0 is ignored: no write, no pointer change.
  - Simultaneous push and pop: count unchanged; both pointers advance.
  - Pointers wrap modulo BUFFER_DEPTH.
  - data_out = mem[rd_ptr], combinational read. A flit written at edge N is visible on data_out after edge N.
  - count width is clog2(BUFFER_DEPTH)+1.
- FSM (Moore outputs):
  - S_IDLE: all outputs 0. Go to S_REQ when count!=0.
  - S_REQ: h=1. Go to S_HEADER on ack_h; h drops in the same cycle the state changes.
  - S_HEADER: sender=1; data_av=(count!=0). On pop go to S_SIZE.
  - S_SIZE: sender=1; data_av=(count!=0). On pop, latch size_cnt=data_out. If data_out==0 go to S_END, else go to S_PAYLOAD.
  - S_PAYLOAD: sender=1; data_av=(count!=0). Each pop decrements size_cnt. A pop with size_cnt==1 goes to S_END.
  - S_END: eop=1, sender=0, data_av=0 for exactly one cycle, then S_IDLE.
- data_av is gated by count!=0. An empty FIFO mid-packet stalls the output without changing state.
- Latency:
  - Header write at edge N gives h high after edge N+2.
  - Earliest header pop is 1 cycle after ack_h.
  - After that, 1 flit per cycle when flits are present and data_ack=1.
- ack_h outside S_REQ is ignored. data_ack while data_av=0 is ignored.
- Flits of the next packet may enter the FIFO during S_PAYLOAD or S_END. Their header is only requested after S_IDLE, so the minimum inter-packet gap at h is 2 cycles after eop.

Decomposition:
- Package hermes_pkg:
  - flit_t typedef (logic [FLIT_WIDTH-1:0]).
  - in_state_t enum {S_IDLE, S_REQ, S_HEADER, S_SIZE, S_PAYLOAD, S_END}.
  - Constants HEADER_IDX=0 and SIZE_IDX=1.
- Sub-module hermes_flit_fifo: memory, pointers, count, credit.
- Top-level hermes_input_buffer contains the packet FSM and size counter.

Test Plan:
- Basic packet:
  - Stimulus: push 0x0011, 0x0003, 0x000A, 0x000B, 0x000C back-to-back; ack_h one cycle after h; data_ack held 1.
  - Response: data_out sequence 0x0011, 0x0003, 0x000A, 0x000B, 0x000C on consecutive cycles; eop one cycle after 0x000C popped; sender high header through tail.
- Full/backpressure:
  - Stimulus: BUFFER_DEPTH=4; no ack_h; push 6 flits.
  - Response: credit_o=0 after 4th push; flits 5 and 6 dropped; count stays 4; data_out=first flit.
- Zero size:
  - Stimulus: push 0x0022, 0x0000, then next header 0x0033, 0x0001, 0x0055.
  - Response: first packet ends after size pop with eop; second packet gets h, 3 pops, eop.
- Stall mid-packet:
  - Stimulus: size 4; upstream rx gaps of 2 cycles between payloads.
  - Response: data_av low during gaps; state remains S_PAYLOAD; 4 payloads delivered; single eop.
- Push/pop at full:
  - Stimulus: DEPTH=4 full and streaming with data_ack=1; rx asserted when credit_o returns.
  - Response: count oscillates 3/4; no flit lost or duplicated; order preserved across pointer wrap.
- Reset mid-payload:
  - Stimulus: assert reset=0 for 1 cycle after 2 of 5 payloads.
  - Response: next cycle h=0, data_av=0, sender=0, eop=0, credit_o=1, count=0; new packet afterwards processed normally.
